// File: rtl/preg_release_unit_pkg.sv
// Shared constants and types for the physical-register release unit.
package preg_release_unit_pkg;

    localparam int unsigned ROB_SIZE  = 16;
    localparam int unsigned NUM_PREGS = 64;
    localparam int unsigned PREG_W    = $clog2(NUM_PREGS);
    localparam int unsigned IDX_W     = $clog2(ROB_SIZE);
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [1:0] {StIdle, StWalk, StReturn} rel_state_t;

    // ROB_SIZE need not be a power of two, so wrap explicitly.
    function automatic logic [IDX_W-1:0] rob_wrap_inc(input logic [IDX_W-1:0] ptr,
                                                      input logic [1:0]       step);
        logic [IDX_W:0] sum;
        sum = {1'b0, ptr} + {{(IDX_W-1){1'b0}}, step};
        if (sum >= (IDX_W+1)'(ROB_SIZE)) begin
            sum = sum - (IDX_W+1)'(ROB_SIZE);
        end
        return sum[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/preg_release_unit_compact2.sv
// Two-slot qualify and compact: a slot qualifies when valid, writes rd, and preg != 0.
module preg_compact2
    import preg_release_unit_pkg::*;
(
    input  logic              valid_0,
    input  logic              has_rd_0,
    input  logic [PREG_W-1:0] preg_0,
    input  logic              valid_1,
    input  logic              has_rd_1,
    input  logic [PREG_W-1:0] preg_1,
    output logic              out_valid_0,
    output logic              out_valid_1,
    output logic [PREG_W-1:0] out_preg_0,
    output logic [PREG_W-1:0] out_preg_1,
    output logic [1:0]        count
);

    logic q0, q1;

    assign q0 = valid_0 && has_rd_0 && (preg_0 != '0);
    assign q1 = valid_1 && has_rd_1 && (preg_1 != '0);

    assign out_valid_0 = q0 | q1;
    assign out_valid_1 = q0 & q1;
    assign out_preg_0  = q0 ? preg_0 : (q1 ? preg_1 : '0);
    assign out_preg_1  = (q0 & q1) ? preg_1 : '0;
    assign count       = {q0 & q1, q0 ^ q1};

endmodule

// File: rtl/preg_release_unit.sv
// Turns commit stale mappings into free pulses and gathers squashed pregs on flush for
// a single bulk return.
module preg_release_unit
    import preg_release_unit_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             commit_valid_0,
    input  logic                             commit_valid_1,
    input  logic                             commit_has_rd_0,
    input  logic                             commit_has_rd_1,
    input  logic [PREG_W-1:0]                commit_old_preg_0,
    input  logic [PREG_W-1:0]                commit_old_preg_1,
    input  logic                             flush_req,
    input  logic [IDX_W-1:0]                 flush_start,
    input  logic [CNT_W-1:0]                 flush_num,
    output logic [IDX_W-1:0]                 rob_rd_idx_0,
    output logic [IDX_W-1:0]                 rob_rd_idx_1,
    input  logic                             rob_rd_has_rd_0,
    input  logic                             rob_rd_has_rd_1,
    input  logic [PREG_W-1:0]                rob_rd_preg_0,
    input  logic [PREG_W-1:0]                rob_rd_preg_1,
    output logic                             free,
    output logic [PREG_W-1:0]                free_preg,
    output logic                             free_1,
    output logic [PREG_W-1:0]                free_preg_1,
    output logic                             flush_free_en,
    output logic [CNT_W-1:0]                 flush_free_count,
    output logic [ROB_SIZE-1:0][PREG_W-1:0]  flush_free_pregs,
    output logic                             busy
);

    rel_state_t                      state_q, state_d;
    logic [IDX_W-1:0]                ptr_q, ptr_d;
    logic [CNT_W-1:0]                rem_q, rem_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [ROB_SIZE-1:0][PREG_W-1:0] gather_q, gather_d;

    logic              free_q, free_1_q;
    logic [PREG_W-1:0] free_preg_q, free_preg_1_q;

    logic              cm_v0, cm_v1;
    logic [PREG_W-1:0] cm_p0, cm_p1;
    logic [1:0]        cm_cnt;

    logic              wk_v0, wk_v1;
    logic [PREG_W-1:0] wk_p0, wk_p1;
    logic [1:0]        wk_cnt;
    logic              wk_slot1;
    logic [1:0]        wk_step;

    assign busy     = (state_q != StIdle);
    assign wk_slot1 = (state_q == StWalk) && (rem_q >= CNT_W'(2));
    assign wk_step  = wk_slot1 ? 2'd2 : 2'd1;

    // The ROB is frozen while busy, so commit inputs are dropped then.
    preg_compact2 u_commit_compact (
        .valid_0     (commit_valid_0 && !busy),
        .has_rd_0    (commit_has_rd_0),
        .preg_0      (commit_old_preg_0),
        .valid_1     (commit_valid_1 && !busy),
        .has_rd_1    (commit_has_rd_1),
        .preg_1      (commit_old_preg_1),
        .out_valid_0 (cm_v0),
        .out_valid_1 (cm_v1),
        .out_preg_0  (cm_p0),
        .out_preg_1  (cm_p1),
        .count       (cm_cnt)
    );

    preg_compact2 u_walk_compact (
        .valid_0     (state_q == StWalk),
        .has_rd_0    (rob_rd_has_rd_0),
        .preg_0      (rob_rd_preg_0),
        .valid_1     (wk_slot1),
        .has_rd_1    (rob_rd_has_rd_1),
        .preg_1      (rob_rd_preg_1),
        .out_valid_0 (wk_v0),
        .out_valid_1 (wk_v1),
        .out_preg_0  (wk_p0),
        .out_preg_1  (wk_p1),
        .count       (wk_cnt)
    );

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        rem_d            = rem_q;
        cnt_d            = cnt_q;
        gather_d         = gather_q;
        rob_rd_idx_0     = '0;
        rob_rd_idx_1     = '0;
        flush_free_en    = 1'b0;
        flush_free_count = '0;
        flush_free_pregs = '0;
        unique case (state_q)
            StIdle: begin
                if (flush_req && (flush_num != '0)) begin
                    ptr_d   = flush_start;
                    rem_d   = flush_num;
                    cnt_d   = '0;
                    state_d = StWalk;
                end
            end
            StWalk: begin
                rob_rd_idx_0 = ptr_q;
                rob_rd_idx_1 = rob_wrap_inc(ptr_q, 2'd1);
                for (int i = 0; i < ROB_SIZE; i++) begin
                    if (wk_v0 && (CNT_W'(i) == cnt_q)) gather_d[i] = wk_p0;
                    if (wk_v1 && (CNT_W'(i) == cnt_q + CNT_W'(1))) gather_d[i] = wk_p1;
                end
                cnt_d = cnt_q + {3'b0, wk_cnt};
                ptr_d = rob_wrap_inc(ptr_q, wk_step);
                rem_d = rem_q - {3'b0, wk_step};
                if (rem_d == '0) begin
                    state_d = (cnt_d != '0) ? StReturn : StIdle;
                end
            end
            StReturn: begin
                flush_free_en    = 1'b1;
                flush_free_count = cnt_q;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    if (CNT_W'(i) < cnt_q) flush_free_pregs[i] = gather_q[i];
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            gather_q      <= '0;
            free_q        <= 1'b0;
            free_1_q      <= 1'b0;
            free_preg_q   <= '0;
            free_preg_1_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            rem_q         <= rem_d;
            cnt_q         <= cnt_d;
            gather_q      <= gather_d;
            free_q        <= cm_v0;
            free_1_q      <= cm_v1;
            free_preg_q   <= cm_p0;
            free_preg_1_q <= cm_p1;
        end
    end

    assign free        = free_q;
    assign free_1      = free_1_q;
    assign free_preg   = free_preg_q;
    assign free_preg_1 = free_preg_1_q;

endmodule

// File: tb/tb_preg_release_unit.sv
// Randomized self-checking bench for preg_release_unit against a list-based reference model.
module tb_preg_release_unit;
    import preg_release_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                            rst;
    logic                            commit_valid_0, commit_valid_1;
    logic                            commit_has_rd_0, commit_has_rd_1;
    logic [PREG_W-1:0]               commit_old_preg_0, commit_old_preg_1;
    logic                            flush_req;
    logic [IDX_W-1:0]                flush_start;
    logic [CNT_W-1:0]                flush_num;
    logic [IDX_W-1:0]                rob_rd_idx_0, rob_rd_idx_1;
    logic                            rob_rd_has_rd_0, rob_rd_has_rd_1;
    logic [PREG_W-1:0]               rob_rd_preg_0, rob_rd_preg_1;
    logic                            free, free_1;
    logic [PREG_W-1:0]               free_preg, free_preg_1;
    logic                            flush_free_en;
    logic [CNT_W-1:0]                flush_free_count;
    logic [ROB_SIZE-1:0][PREG_W-1:0] flush_free_pregs;
    logic                            busy;

    bit                rob_has  [ROB_SIZE];
    logic [PREG_W-1:0] rob_preg [ROB_SIZE];

    int checks = 0;
    int errors = 0;

    preg_release_unit dut (
        .clk               (clk),
        .rst               (rst),
        .commit_valid_0    (commit_valid_0),
        .commit_valid_1    (commit_valid_1),
        .commit_has_rd_0   (commit_has_rd_0),
        .commit_has_rd_1   (commit_has_rd_1),
        .commit_old_preg_0 (commit_old_preg_0),
        .commit_old_preg_1 (commit_old_preg_1),
        .flush_req         (flush_req),
        .flush_start       (flush_start),
        .flush_num         (flush_num),
        .rob_rd_idx_0      (rob_rd_idx_0),
        .rob_rd_idx_1      (rob_rd_idx_1),
        .rob_rd_has_rd_0   (rob_rd_has_rd_0),
        .rob_rd_has_rd_1   (rob_rd_has_rd_1),
        .rob_rd_preg_0     (rob_rd_preg_0),
        .rob_rd_preg_1     (rob_rd_preg_1),
        .free              (free),
        .free_preg         (free_preg),
        .free_1            (free_1),
        .free_preg_1       (free_preg_1),
        .flush_free_en     (flush_free_en),
        .flush_free_count  (flush_free_count),
        .flush_free_pregs  (flush_free_pregs),
        .busy              (busy)
    );

    // Asynchronous ROB read model.
    always_comb begin
        rob_rd_has_rd_0 = rob_has[rob_rd_idx_0];
        rob_rd_preg_0   = rob_preg[rob_rd_idx_0];
        rob_rd_has_rd_1 = rob_has[rob_rd_idx_1];
        rob_rd_preg_1   = rob_preg[rob_rd_idx_1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_commit(input bit v0, input bit h0, input logic [PREG_W-1:0] p0,
                              input bit v1, input bit h1, input logic [PREG_W-1:0] p1);
        commit_valid_0    = v0;
        commit_has_rd_0   = h0;
        commit_old_preg_0 = p0;
        commit_valid_1    = v1;
        commit_has_rd_1   = h1;
        commit_old_preg_1 = p1;
    endtask

    task automatic random_commit();
        set_commit(1'($urandom), 1'($urandom), PREG_W'($urandom),
                   1'($urandom), 1'($urandom), PREG_W'($urandom));
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (free !== 1'b0 || free_1 !== 1'b0 || free_preg !== '0 || free_preg_1 !== '0) begin
            errors++;
            $display("FAIL %s_free: got free=%b/%0d free_1=%b/%0d want all 0",
                     tag, free, free_preg, free_1, free_preg_1);
        end
        checks++;
        if (flush_free_en !== 1'b0 || flush_free_count !== '0 || flush_free_pregs !== '0) begin
            errors++;
            $display("FAIL %s_bulk: got en=%b count=%0d pregs=%h want 0", tag,
                     flush_free_en, flush_free_count, flush_free_pregs);
        end
        checks++;
        if (busy !== 1'b0 || rob_rd_idx_0 !== '0 || rob_rd_idx_1 !== '0) begin
            errors++;
            $display("FAIL %s_busy_idx: got busy=%b idx0=%0d idx1=%0d want 0", tag,
                     busy, rob_rd_idx_0, rob_rd_idx_1);
        end
    endtask

    // One commit cycle; expected frees come from a list of qualifying pregs in slot order.
    task automatic do_commit(input string tag, input bit v0, input bit h0,
                             input logic [PREG_W-1:0] p0, input bit v1, input bit h1,
                             input logic [PREG_W-1:0] p1);
        logic [PREG_W-1:0] q[$];
        if (v0 && h0 && p0 != 0) q.push_back(p0);
        if (v1 && h1 && p1 != 0) q.push_back(p1);
        set_commit(v0, h0, p0, v1, h1, p1);
        tick();
        set_commit(0, 0, '0, 0, 0, '0);
        checks++;
        if (free !== (q.size() >= 1) || (q.size() >= 1 && free_preg !== q[0])) begin
            errors++;
            $display("FAIL %s_port0: got free=%b preg=%0d want free=%b preg=%0d", tag,
                     free, free_preg, q.size() >= 1, (q.size() >= 1) ? q[0] : 0);
        end
        checks++;
        if (free_1 !== (q.size() == 2) || (q.size() == 2 && free_preg_1 !== q[1])) begin
            errors++;
            $display("FAIL %s_port1: got free_1=%b preg=%0d want free_1=%b preg=%0d", tag,
                     free_1, free_preg_1, q.size() == 2, (q.size() == 2) ? q[1] : 0);
        end
    endtask

    task automatic run_flush(input string tag, input logic [IDX_W-1:0] start,
                             input logic [CNT_W-1:0] num, input bit inject);
        logic [PREG_W-1:0]               exp_q[$];
        logic [ROB_SIZE-1:0][PREG_W-1:0] exp_pregs;
        int n, walk, p, idx;
        n = int'(num);
        for (int k = 0; k < n; k++) begin
            idx = (int'(start) + k) % ROB_SIZE;
            if (rob_has[idx] && rob_preg[idx] != 0) exp_q.push_back(rob_preg[idx]);
        end
        exp_pregs = '0;
        foreach (exp_q[i]) exp_pregs[i] = exp_q[i];
        walk = (n + 1) / 2;

        set_commit(0, 0, '0, 0, 0, '0);
        flush_req   = 1'b1;
        flush_start = start;
        flush_num   = num;
        tick();
        flush_req = 1'b0;

        for (int c = 0; c < walk; c++) begin
            p = (int'(start) + 2 * c) % ROB_SIZE;
            checks++;
            if (busy !== 1'b1 || flush_free_en !== 1'b0) begin
                errors++;
                $display("FAIL %s_walk%0d_busy: got busy=%b en=%b want busy=1 en=0", tag, c,
                         busy, flush_free_en);
            end
            checks++;
            if (rob_rd_idx_0 !== IDX_W'(p) || rob_rd_idx_1 !== IDX_W'((p + 1) % ROB_SIZE)) begin
                errors++;
                $display("FAIL %s_walk%0d_idx: got %0d/%0d want %0d/%0d", tag, c,
                         rob_rd_idx_0, rob_rd_idx_1, p, (p + 1) % ROB_SIZE);
            end
            checks++;
            if (free !== 1'b0 || free_1 !== 1'b0) begin
                errors++;
                $display("FAIL %s_walk%0d_free: got %b/%b want 0/0", tag, c, free, free_1);
            end
            if (inject) random_commit();
            tick();
        end

        if (exp_q.size() > 0) begin
            checks++;
            if (busy !== 1'b1 || flush_free_en !== 1'b1 || free !== 1'b0 || free_1 !== 1'b0) begin
                errors++;
                $display("FAIL %s_ret_flags: got busy=%b en=%b free=%b/%b want 1 1 0 0", tag,
                         busy, flush_free_en, free, free_1);
            end
            checks++;
            if (flush_free_count !== CNT_W'(exp_q.size())) begin
                errors++;
                $display("FAIL %s_ret_count: got %0d want %0d", tag, flush_free_count,
                         exp_q.size());
            end
            checks++;
            if (flush_free_pregs !== exp_pregs) begin
                errors++;
                $display("FAIL %s_ret_pregs: got %h want %h", tag, flush_free_pregs, exp_pregs);
            end
            if (inject) random_commit();
            tick();
        end

        checks++;
        if (busy !== 1'b0 || flush_free_en !== 1'b0 || free !== 1'b0 || free_1 !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: got busy=%b en=%b free=%b/%b want all 0", tag,
                     busy, flush_free_en, free, free_1);
        end
        set_commit(0, 0, '0, 0, 0, '0);
    endtask

    task automatic fill_rob_random();
        for (int i = 0; i < ROB_SIZE; i++) begin
            rob_has[i]  = 1'($urandom);
            rob_preg[i] = ($urandom_range(0, 4) == 0) ? '0 : PREG_W'($urandom);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        flush_req = 1'b0;
        flush_start = '0;
        flush_num   = '0;
        set_commit(1, 1, PREG_W'(9), 1, 1, PREG_W'(10));
        tick();
        tick();
        rst = 1'b0;
        set_commit(0, 0, '0, 0, 0, '0);
        check_idle_outputs("reset");
    endtask

    task automatic test_commit_directed();
        do_commit("commit_pair", 1, 1, PREG_W'(33), 1, 1, PREG_W'(40));
        do_commit("commit_slot1_only", 1, 0, PREG_W'(12), 1, 1, PREG_W'(35));
        do_commit("commit_p0", 1, 1, PREG_W'(0), 0, 0, PREG_W'(0));
        do_commit("commit_slot0_only", 1, 1, PREG_W'(7), 1, 1, PREG_W'(0));
    endtask

    task automatic test_commit_random();
        for (int i = 0; i < 40; i++) begin
            do_commit("commit_rand", 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? '0 : PREG_W'($urandom),
                      1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? '0 : PREG_W'($urandom));
        end
    endtask

    task automatic test_flush_directed();
        for (int i = 0; i < ROB_SIZE; i++) begin
            rob_has[i]  = 1'b0;
            rob_preg[i] = PREG_W'(i + 20);
        end
        rob_has[14] = 1'b1; rob_preg[14] = PREG_W'(40);
        rob_has[0]  = 1'b1; rob_preg[0]  = PREG_W'(41);
        rob_has[1]  = 1'b1; rob_preg[1]  = PREG_W'(0);
        rob_has[2]  = 1'b1; rob_preg[2]  = PREG_W'(47);
        run_flush("flush_wrap", IDX_W'(14), CNT_W'(5), 1'b1);
    endtask

    task automatic test_flush_nodest();
        for (int i = 0; i < ROB_SIZE; i++) begin
            rob_has[i]  = 1'b0;
            rob_preg[i] = PREG_W'($urandom_range(1, NUM_PREGS - 1));
        end
        run_flush("flush_nodest", IDX_W'($urandom_range(0, ROB_SIZE - 1)), CNT_W'(4), 1'b1);
    endtask

    task automatic test_flush_full();
        for (int i = 0; i < ROB_SIZE; i++) begin
            rob_has[i]  = 1'b1;
            rob_preg[i] = PREG_W'($urandom_range(1, NUM_PREGS - 1));
        end
        run_flush("flush_full", IDX_W'($urandom_range(0, ROB_SIZE - 1)),
                  CNT_W'(ROB_SIZE), 1'b1);
    endtask

    task automatic test_flush_zero();
        fill_rob_random();
        run_flush("flush_zero", IDX_W'(5), CNT_W'(0), 1'b0);
    endtask

    task automatic test_reset_mid_walk();
        fill_rob_random();
        flush_req   = 1'b1;
        flush_start = IDX_W'(3);
        flush_num   = CNT_W'(10);
        tick();
        flush_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("reset_walk");
        run_flush("post_reset", IDX_W'($urandom_range(0, ROB_SIZE - 1)),
                  CNT_W'($urandom_range(1, ROB_SIZE)), 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 25; i++) begin
            fill_rob_random();
            run_flush("flush_rand", IDX_W'($urandom_range(0, ROB_SIZE - 1)),
                      CNT_W'($urandom_range(0, ROB_SIZE)), 1'b1);
            do_commit("commit_between", 1'($urandom), 1'($urandom), PREG_W'($urandom),
                      1'($urandom), 1'($urandom), PREG_W'($urandom));
        end
    endtask

    initial begin
        set_commit(0, 0, '0, 0, 0, '0);
        for (int i = 0; i < ROB_SIZE; i++) begin
            rob_has[i]  = 1'b0;
            rob_preg[i] = '0;
        end
        test_reset();
        test_commit_directed();
        test_commit_random();
        test_flush_directed();
        test_flush_nodest();
        test_flush_full();
        test_flush_zero();
        test_reset_mid_walk();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
